// File: rtl/cache_ctrl_master_pkg.sv
// Cache control port address map plus the master's FSM state and operation encodings.
package cache_ctrl_master_pkg;

  localparam int CTRL_ADDR_W = 4;

  // Responder register map (the subset this master uses)
  localparam logic [CTRL_ADDR_W-1:0] ADDR_BUFFER_EMPTY     = 4'd1;
  localparam logic [CTRL_ADDR_W-1:0] ADDR_CACHE_HIT        = 4'd3;
  localparam logic [CTRL_ADDR_W-1:0] ADDR_CACHE_MISS       = 4'd4;
  localparam logic [CTRL_ADDR_W-1:0] ADDR_RESET_COUNTER    = 4'd9;
  localparam logic [CTRL_ADDR_W-1:0] ADDR_CACHE_INVALIDATE = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_POLL = 3'd0,
    OP_INV  = 3'd1,
    OP_HIT  = 3'd2,
    OP_MISS = 3'd3,
    OP_CLR  = 3'd4
  } op_t;

  function automatic logic [CTRL_ADDR_W-1:0] op_addr(input op_t op);
    logic [CTRL_ADDR_W-1:0] addr;
    case (op)
      OP_POLL: addr = ADDR_BUFFER_EMPTY;
      OP_INV:  addr = ADDR_CACHE_INVALIDATE;
      OP_HIT:  addr = ADDR_CACHE_HIT;
      OP_MISS: addr = ADDR_CACHE_MISS;
      OP_CLR:  addr = ADDR_RESET_COUNTER;
      default: addr = ADDR_BUFFER_EMPTY;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/cache_ctrl_master_req.sv
// Single-outstanding control request issuer: valid is one registered cycle per accepted request.
// Latency: request visible the cycle after req; a response is only accepted once valid has dropped.
module cache_ctrl_master_req
  import cache_ctrl_master_pkg::*;
#(
  parameter int FE_DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req,
  input  logic [CTRL_ADDR_W-1:0] req_addr,
  output logic                   rsp,
  output logic [FE_DATA_W-1:0]   rsp_data,
  output logic                   ctrl_valid,
  output logic [CTRL_ADDR_W-1:0] ctrl_addr,
  input  logic [FE_DATA_W-1:0]   ctrl_rdata,
  input  logic                   ctrl_ready
);

  logic pending;
  logic accept;

  // The responder answers no earlier than the cycle after valid, so a ready
  // coinciding with our own valid (or with nothing pending) is stale.
  assign rsp      = pending & ~ctrl_valid & ctrl_ready;
  assign rsp_data = ctrl_rdata;
  assign accept   = req & (~pending | rsp);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      ctrl_valid <= 1'b0;
      ctrl_addr  <= '0;
    end else begin
      ctrl_valid <= accept;
      ctrl_addr  <= accept ? req_addr : '0;
      if (accept) begin
        pending <= 1'b1;
      end else if (rsp) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cache_ctrl_master.sv
// One-shot drain/invalidate/snapshot master for the cache control port; best case done 11 cycles after start.
// Waits indefinitely on a slow responder; start outside IDLE is dropped, not queued.
module cache_ctrl_master
  import cache_ctrl_master_pkg::*;
#(
  parameter int FE_DATA_W      = 32,
  parameter int POLL_MAX       = 255,
  parameter int CLR_AFTER_SNAP = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic [FE_DATA_W-1:0]   hit_snap,
  output logic [FE_DATA_W-1:0]   miss_snap,
  output logic                   ctrl_valid,
  output logic [CTRL_ADDR_W-1:0] ctrl_addr,
  input  logic [FE_DATA_W-1:0]   ctrl_rdata,
  input  logic                   ctrl_ready
);

  localparam int                POLL_W   = $clog2(POLL_MAX + 1);
  localparam logic [POLL_W-1:0] POLL_LIM = POLL_W'(POLL_MAX);

  state_t               state;
  state_t               state_nxt;
  op_t                  op;
  op_t                  op_nxt;
  logic [POLL_W-1:0]    poll_cnt;
  logic [POLL_W-1:0]    poll_nxt;
  logic [POLL_W-1:0]    poll_inc;
  logic                 timeout_nxt;
  logic                 hit_cap;
  logic                 miss_cap;
  logic                 req;
  logic                 rsp;
  logic [FE_DATA_W-1:0] rsp_data;

  assign poll_inc = poll_cnt + 1'b1;
  assign req      = (state_nxt == ST_REQ);

  cache_ctrl_master_req #(
    .FE_DATA_W(FE_DATA_W)
  ) u_req (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_addr   (op_addr(op_nxt)),
    .rsp        (rsp),
    .rsp_data   (rsp_data),
    .ctrl_valid (ctrl_valid),
    .ctrl_addr  (ctrl_addr),
    .ctrl_rdata (ctrl_rdata),
    .ctrl_ready (ctrl_ready)
  );

  always_comb begin
    state_nxt   = state;
    op_nxt      = op;
    poll_nxt    = poll_cnt;
    timeout_nxt = timeout;
    hit_cap     = 1'b0;
    miss_cap    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt   = ST_REQ;
          op_nxt      = OP_POLL;
          poll_nxt    = '0;
          timeout_nxt = 1'b0;
        end
      end
      ST_REQ: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (rsp) begin
          state_nxt = ST_REQ;
          case (op)
            OP_POLL: begin
              if (rsp_data[0]) begin
                op_nxt = OP_INV;
              end else begin
                // Counter saturates at the limit, so it can never wrap.
                poll_nxt = poll_inc;
                if (poll_inc == POLL_LIM) begin
                  timeout_nxt = 1'b1;
                  state_nxt   = ST_DONE;
                end
              end
            end
            OP_INV: op_nxt = OP_HIT;
            OP_HIT: begin
              hit_cap = 1'b1;
              op_nxt  = OP_MISS;
            end
            OP_MISS: begin
              miss_cap = 1'b1;
              if (CLR_AFTER_SNAP != 0) begin
                op_nxt = OP_CLR;
              end else begin
                state_nxt = ST_DONE;
              end
            end
            OP_CLR:  state_nxt = ST_DONE;
            default: state_nxt = ST_DONE;
          endcase
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op        <= OP_POLL;
      poll_cnt  <= '0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_snap  <= '0;
      miss_snap <= '0;
    end else begin
      state    <= state_nxt;
      op       <= op_nxt;
      poll_cnt <= poll_nxt;
      timeout  <= timeout_nxt;
      // Status flags follow the next state so they line up with the registered state.
      busy     <= (state_nxt == ST_REQ) || (state_nxt == ST_WAIT);
      done     <= (state_nxt == ST_DONE);
      if (hit_cap) begin
        hit_snap <= rsp_data;
      end
      if (miss_cap) begin
        miss_snap <= rsp_data;
      end
    end
  end

endmodule
